// File: rtl/ex_mem_ctrl_pipe.sv
// Elastic EX->MEM control-bundle pipeline: DEPTH register stages with valid/ready,
// synchronous flush and a saturating count of memory ops killed by flush.
module ex_mem_ctrl_pipe #(
  parameter int XLEN   = 32,
  parameter int FUNC_W = 5,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   jump_pc_in,
  input  logic [FUNC_W-1:0] instruction_func_in,
  input  logic              force_jump_in,
  input  logic              branch_in,
  input  logic              mem_write_in,
  input  logic              mem_read_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   jump_pc_out,
  output logic [FUNC_W-1:0] instruction_func_out,
  output logic              force_jump_out,
  output logic              branch_out,
  output logic              mem_write_out,
  output logic              mem_read_out,
  output logic [2:0]        occupancy,
  output logic [CNT_W-1:0]  flushed_mem_ops
);

  localparam int PW = XLEN + FUNC_W + 4;

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("ex_mem_ctrl_pipe: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] advance, load_en;
  logic [DEPTH:0]   xfer_chain;
  logic [PW-1:0]    pay_q   [DEPTH];
  logic [PW-1:0]    pay_d   [DEPTH];
  logic [PW-1:0]    pay_src [DEPTH];
  logic [PW-1:0]    in_pay;
  logic [PW-1:0]    last_pay;
  logic [CNT_W-1:0] flushed_q, flushed_d;
  logic [2:0]       kills;
  logic [CNT_W+2:0] cnt_sum;
  logic             in_xfer;

  assign in_pay = {jump_pc_in, instruction_func_in, force_jump_in, branch_in,
                   mem_write_in, mem_read_in};

  // Ready ripples from the output back to stage 0 so a full pipe still moves every cycle.
  always_comb begin
    logic [DEPTH:0] rdy;
    rdy        = '0;
    advance    = '0;
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      advance[k] = valid_q[k] & rdy[k+1];
      rdy[k]     = ~valid_q[k] | advance[k];
    end
    in_ready = ~flush & rdy[0];
  end

  assign in_xfer    = in_valid & in_ready;
  assign xfer_chain = {advance, in_xfer};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign pay_src[gi] = in_pay;
    end else begin : g_body
      assign pay_src[gi] = pay_q[gi-1];
    end
    assign load_en[gi] = xfer_chain[gi] & ~flush;
    assign valid_d[gi] = ~flush & (xfer_chain[gi] | (valid_q[gi] & ~advance[gi]));
    assign pay_d[gi]   = load_en[gi] ? pay_src[gi] : pay_q[gi];
  end

  // A last-stage bundle leaving during the flush cycle was delivered, not killed.
  always_comb begin
    kills = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k] && (pay_q[k][1] || pay_q[k][0]) && !(k == DEPTH - 1 && advance[k]))
        kills = kills + 3'd1;
    end
    cnt_sum   = {3'b000, flushed_q} + {{CNT_W{1'b0}}, kills};
    flushed_d = flushed_q;
    if (flush) begin
      if (cnt_sum > {3'b000, {CNT_W{1'b1}}})
        flushed_d = {CNT_W{1'b1}};
      else
        flushed_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      valid_q   <= '0;
      flushed_q <= '0;
      for (int k = 0; k < DEPTH; k++) pay_q[k] <= '0;
    end else begin
      valid_q   <= valid_d;
      flushed_q <= flushed_d;
      for (int k = 0; k < DEPTH; k++) pay_q[k] <= pay_d[k];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + {2'b00, valid_q[k]};
  end

  assign last_pay             = pay_q[DEPTH-1];
  assign out_valid            = valid_q[DEPTH-1];
  assign jump_pc_out          = last_pay[4+FUNC_W +: XLEN];
  assign instruction_func_out = last_pay[4 +: FUNC_W];
  assign force_jump_out       = last_pay[3] & out_valid;
  assign branch_out           = last_pay[2] & out_valid;
  assign mem_write_out        = last_pay[1] & out_valid;
  assign mem_read_out         = last_pay[0] & out_valid;
  assign flushed_mem_ops      = flushed_q;

endmodule
